// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbitro_rr4 round-robin arbiter.
//   NUM_REQ     : number of requesters sharing the data path (A..D)
//   req_idx_t   : index of one requester, also the mux select width
//   arb_state_t : arbiter FSM state
//   onehot()    : converts a requester index into a one-hot grant vector
package arb_pkg;

   localparam int NUM_REQ = 4;

   typedef logic [1:0] req_idx_t;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   function automatic logic [NUM_REQ-1:0] onehot(input req_idx_t idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/arbitro_rr4_if.sv
// Request/grant/data bundle between the four requesters and the arbiter.
//   req        : request vector, bit i = requester i (0=A .. 3=D)
//   datoA..D   : requester data words, BITS wide
//   grant      : one-hot current owner, 0000 when idle
//   selDato    : index of the current owner (mux select)
//   datoOutput : registered data word of the owner
//   datoValid  : datoOutput carries data captured from an owner
// Modports: master = requester side, slave = arbiter side.
interface arbitro_rr4_if #(
   parameter int BITS = 32
);
   import arb_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [BITS-1:0]    datoA;
   logic [BITS-1:0]    datoB;
   logic [BITS-1:0]    datoC;
   logic [BITS-1:0]    datoD;
   logic [NUM_REQ-1:0] grant;
   req_idx_t           selDato;
   logic [BITS-1:0]    datoOutput;
   logic               datoValid;

   modport master (
      output req, datoA, datoB, datoC, datoD,
      input  grant, selDato, datoOutput, datoValid
   );

   modport slave (
      input  req, datoA, datoB, datoC, datoD,
      output grant, selDato, datoOutput, datoValid
   );

endinterface

// File: rtl/multiplexor4.sv
// Combinational 4:1 data multiplexor.
//   a, b, c, d : BITS-wide inputs selected by sel = 0, 1, 2, 3
//   sel        : select index
//   y          : selected word
module multiplexor4
   import arb_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic [BITS-1:0] c,
   input  logic [BITS-1:0] d,
   input  req_idx_t        sel,
   output logic [BITS-1:0] y
);

   always_comb begin
      case (sel)
         2'd0:    y = a;
         2'd1:    y = b;
         2'd2:    y = c;
         default: y = d;
      endcase
   end

endmodule

// File: rtl/arbitro_rr4.sv
// Round-robin arbiter sharing one BITS-wide data path between four
// requesters. The owner keeps the path while its request stays high; when it
// drops, the next pending requester (searched from owner+1, wrapping 3->0)
// takes over on the very next edge with no idle cycle. The selected word is
// registered one cycle after the grant together with a valid flag.
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : arbitro_rr4_if.slave (req, datoA..D in; grant, selDato,
//            datoOutput, datoValid out)
// Optional feature, macro ARB_TIMEOUT_EN: bounds one owner's tenure to
// MAX_HOLD cycles when another requester is waiting.
module arbitro_rr4
   import arb_pkg::*;
#(
   parameter int BITS     = 32,
   parameter int MAX_HOLD = 16
) (
   input logic         clk,
   input logic         reset,
   arbitro_rr4_if.slave bus
);

   arb_state_t         state;
   req_idx_t           last_grant;
   logic [BITS-1:0]    mux_out;
   logic [NUM_REQ-1:0] cand;
   req_idx_t           pick;
   req_idx_t           pick_try;
   logic               found;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_cnt;
`else
   logic [7:0] max_hold_unused;
   assign max_hold_unused = 8'(MAX_HOLD);
`endif

   multiplexor4 #(.BITS(BITS)) u_mux (
      .a   (bus.datoA),
      .b   (bus.datoB),
      .c   (bus.datoC),
      .d   (bus.datoD),
      .sel (bus.selDato),
      .y   (mux_out)
   );

   // Picker: while granted, the owner is masked so it can only win again
   // after every other requester has been considered.
   always_comb begin
      cand = bus.req;
      if (state == GRANT) begin
         cand = bus.req & ~onehot(bus.selDato);
      end
      found    = 1'b0;
      pick     = last_grant;
      pick_try = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pick_try = last_grant + req_idx_t'(k);
         if (!found && cand[pick_try]) begin
            found = 1'b1;
            pick  = pick_try;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         bus.grant      <= '0;
         bus.selDato    <= '0;
         bus.datoOutput <= '0;
         bus.datoValid  <= 1'b0;
         last_grant     <= 2'd3;
`ifdef ARB_TIMEOUT_EN
         hold_cnt       <= '0;
`endif
      end else begin
         // Data stage: capture the owner's word one cycle after the grant.
         bus.datoValid <= (state == GRANT);
         if (state == GRANT) begin
            bus.datoOutput <= mux_out;
         end

         case (state)
            IDLE: begin
               if (found) begin
                  state       <= GRANT;
                  bus.grant   <= onehot(pick);
                  bus.selDato <= pick;
                  last_grant  <= pick;
`ifdef ARB_TIMEOUT_EN
                  hold_cnt    <= '0;
`endif
               end
            end
            GRANT: begin
               if (!bus.req[bus.selDato]) begin
                  if (found) begin
                     bus.grant   <= onehot(pick);
                     bus.selDato <= pick;
                     last_grant  <= pick;
                  end else begin
                     state     <= IDLE;
                     bus.grant <= '0;
                  end
`ifdef ARB_TIMEOUT_EN
                  hold_cnt <= '0;
`endif
               end
`ifdef ARB_TIMEOUT_EN
               else if (hold_cnt == HOLD_LAST) begin
                  // Tenure used up: yield only if someone else is waiting,
                  // otherwise stay saturated and keep the grant.
                  if (found) begin
                     bus.grant   <= onehot(pick);
                     bus.selDato <= pick;
                     last_grant  <= pick;
                     hold_cnt    <= '0;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arbitro_rr4.sv
// Self-checking bench for arbitro_rr4. Each scenario task drives a table of
// (reset, req, expected grant) rows; tick() pushes the full expected output
// word (grant, selDato, datoValid, datoOutput) into a scoreboard queue and
// advances one clock, and the task pops and compares it inline.
// Built with ARB_TIMEOUT_EN the hold scenario expects 4-cycle alternation.
module tb_arbitro_rr4;

   localparam logic [31:0] DA = 32'hAAAA0000;
   localparam logic [31:0] DB = 32'hBBBB1111;
   localparam logic [31:0] DC = 32'hCCCC2222;
   localparam logic [31:0] DD = 32'hDDDD3333;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   arbitro_rr4_if #(.BITS(32)) bus ();

   arbitro_rr4 #(.BITS(32), .MAX_HOLD(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int passed = 0;

   logic [38:0] exp_q [$];
   logic [3:0]  prev_g   = 4'b0000;
   logic [1:0]  exp_sel  = 2'd0;
   logic [31:0] exp_dout = 32'd0;

   function automatic logic [31:0] owner_data(input logic [3:0] g);
      case (g)
         4'b0001: return DA;
         4'b0010: return DB;
         4'b0100: return DC;
         default: return DD;
      endcase
   endfunction

   function automatic logic [1:0] owner_idx(input logic [3:0] g);
      case (g)
         4'b0001: return 2'd0;
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   // Expected data follows the expected grant of the previous cycle.
   task automatic tick(input logic rs, input logic [3:0] r, input logic [3:0] eg);
      logic v;
      logic [3:0] g;
      if (rs) begin
         g        = 4'b0000;
         v        = 1'b0;
         exp_sel  = 2'd0;
         exp_dout = 32'd0;
      end else begin
         g = eg;
         v = (prev_g != 4'b0000);
         if (v) exp_dout = owner_data(prev_g);
         if (g != 4'b0000) exp_sel = owner_idx(g);
      end
      prev_g = g;
      exp_q.push_back({g, exp_sel, v, exp_dout});
      reset   = rs;
      bus.req = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [38:0] e, got;
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 4'b0000, 4'b0000);
         e = exp_q.pop_front();
         got = {bus.grant, bus.selDato, bus.datoValid, bus.datoOutput};
         checks++;
         if (got !== e)
            $display("FAIL reset[%0d] got grant=%b sel=%0d vld=%b dout=%h need grant=%b sel=%0d vld=%b dout=%h",
                     i, got[38:35], got[34:33], got[32], got[31:0], e[38:35], e[34:33], e[32], e[31:0]);
         else passed++;
      end
   endtask

   task automatic test_single();
      logic [3:0] rq [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
      logic [3:0] eg [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
      logic [38:0] e, got;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, rq[i], eg[i]);
         e = exp_q.pop_front();
         got = {bus.grant, bus.selDato, bus.datoValid, bus.datoOutput};
         checks++;
         if (got !== e)
            $display("FAIL single[%0d] got grant=%b sel=%0d vld=%b dout=%h need grant=%b sel=%0d vld=%b dout=%h",
                     i, got[38:35], got[34:33], got[32], got[31:0], e[38:35], e[34:33], e[32], e[31:0]);
         else passed++;
      end
   endtask

   task automatic test_rotation();
      logic       rs [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [3:0] rq [12] = '{4'b0000, 4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                              4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b1111, 4'b0000};
      logic [3:0] eg [12] = '{4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                              4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0000};
      logic [38:0] e, got;
      for (int i = 0; i < 12; i++) begin
         tick(rs[i], rq[i], eg[i]);
         e = exp_q.pop_front();
         got = {bus.grant, bus.selDato, bus.datoValid, bus.datoOutput};
         checks++;
         if (got !== e)
            $display("FAIL rotation[%0d] got grant=%b sel=%0d vld=%b dout=%h need grant=%b sel=%0d vld=%b dout=%h",
                     i, got[38:35], got[34:33], got[32], got[31:0], e[38:35], e[34:33], e[32], e[31:0]);
         else passed++;
      end
   endtask

   task automatic test_wrap();
      logic [3:0] rq [5] = '{4'b0100, 4'b1001, 4'b1001, 4'b0001, 4'b0000};
      logic [3:0] eg [5] = '{4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0000};
      logic [38:0] e, got;
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, rq[i], eg[i]);
         e = exp_q.pop_front();
         got = {bus.grant, bus.selDato, bus.datoValid, bus.datoOutput};
         checks++;
         if (got !== e)
            $display("FAIL wrap[%0d] got grant=%b sel=%0d vld=%b dout=%h need grant=%b sel=%0d vld=%b dout=%h",
                     i, got[38:35], got[34:33], got[32], got[31:0], e[38:35], e[34:33], e[32], e[31:0]);
         else passed++;
      end
   endtask

   task automatic test_hold();
      logic [38:0] e, got;
      logic [3:0]  r, g;
      for (int i = 0; i < 22; i++) begin
         r = (i >= 1 && i <= 20) ? 4'b0011 : 4'b0000;
         if (i == 0 || i == 21) g = 4'b0000;
`ifdef ARB_TIMEOUT_EN
         else g = (((i - 1) / 4) % 2 == 1) ? 4'b0010 : 4'b0001;
`else
         else g = 4'b0001;
`endif
         tick(i == 0, r, g);
         e = exp_q.pop_front();
         got = {bus.grant, bus.selDato, bus.datoValid, bus.datoOutput};
         checks++;
         if (got !== e)
            $display("FAIL hold[%0d] got grant=%b sel=%0d vld=%b dout=%h need grant=%b sel=%0d vld=%b dout=%h",
                     i, got[38:35], got[34:33], got[32], got[31:0], e[38:35], e[34:33], e[32], e[31:0]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      logic       rs [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0] rq [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0110};
      logic [3:0] eg [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0010};
      logic [38:0] e, got;
      for (int i = 0; i < 6; i++) begin
         tick(rs[i], rq[i], eg[i]);
         e = exp_q.pop_front();
         got = {bus.grant, bus.selDato, bus.datoValid, bus.datoOutput};
         checks++;
         if (got !== e)
            $display("FAIL reset_mid[%0d] got grant=%b sel=%0d vld=%b dout=%h need grant=%b sel=%0d vld=%b dout=%h",
                     i, got[38:35], got[34:33], got[32], got[31:0], e[38:35], e[34:33], e[32], e[31:0]);
         else passed++;
      end
   endtask

   initial begin
      reset     = 1'b1;
      bus.req   = 4'b0000;
      bus.datoA = DA;
      bus.datoB = DB;
      bus.datoC = DC;
      bus.datoD = DD;
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/arbitro_rr4.md
Name: arbitro_rr4

Overview:
- Round-robin arbiter that shares one 32-bit data path between four requesters (A..D).
- Grants exactly one owner at a time and drives the 2-bit select of a 4:1 data multiplexor.
- Registers the selected data word with a valid flag for the downstream consumer (e.g. a shared memory/bus port in the Pac-ARM datapath).
- Owner holds the path while its request stays high; handover to the next pending requester costs no idle cycle.

Parameters:
- BITS, 32, width of each data input and of datoOutput.
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = requester i (0=A, 1=B, 2=C, 3=D).
- datoA, datoB, datoC, datoD  input  BITS each  requester data words.
- grant  output  4  one-hot current owner, or 0000 when idle.
- selDato  output  2  index of current owner; drives the mux select.
- datoOutput  output  BITS  registered mux output.
- datoValid  output  1  datoOutput holds data captured from an owner.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high: `reset` is sampled only on the rising edge of clk.
- Reset values: state=IDLE, grant=0000, selDato=00, datoOutput=0, datoValid=0, lastGrant=3 (so priority search starts at 0), holdCnt=0.
- Reset mid-operation: reset overrides all other activity. At that edge the grant is lost and all reset values apply.
- Picker (combinational): searches req starting at index (lastGrant+1) mod 4, wrapping 3->0, and returns the first set bit plus a found flag.
- State IDLE:
  - If any req bit is set, the next edge loads grant=onehot(pick), selDato=pick, lastGrant=pick, holdCnt=0, and moves to GRANT.
  - Latency from req to grant is 1 cycle.
  - Otherwise the block stays in IDLE with grant=0000 and selDato unchanged.
- State GRANT, owner=selDato:
  - req[owner]=1: hold the grant.
  - req[owner]=0: run the picker with the owner's bit masked.
    - If found, the next edge hands over directly (GRANT->GRANT, new owner, no bubble).
    - If not found, the next edge goes to IDLE with grant=0000.
  - When several requests are pending and the owner drops, the picker decides. Newly asserted requests are treated the same as long-pending ones.
- Data path:
  - Every edge: datoOutput <= mux4(datoA..D, selDato) when state==GRANT; otherwise datoOutput is held.
  - datoValid <= (state==GRANT).
  - Data latency is 1 cycle after grant assertion.
- Invariants:
  - grant is always one-hot or zero.
  - grant[selDato]==1 whenever grant!=0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit holdCnt increments each GRANT cycle in which the owner keeps its request.
  - When holdCnt==MAX_HOLD-1 and the picker (owner masked) finds another requester, the next edge forces a handover to it and clears holdCnt.
  - If no other requester is pending, the owner keeps the grant and holdCnt saturates at MAX_HOLD-1.
- Undefined: no counter exists; the owner holds the grant indefinitely while req[owner]=1.

Decomposition:
- Package arb_pkg:
  - constant NUM_REQ=4.
  - typedef req_idx_t = logic[1:0].
  - typedef enum logic {IDLE, GRANT} arb_state_t.
- Sub-module: instantiate the existing multiplexor4 #(BITS) for data selection, driven by selDato.
- Picker and FSM stay inline.

Test Plan:
1. reset=1 for 2 cycles, req=0000 -> grant=0000, selDato=00, datoValid=0, datoOutput=0.
2. req=0001 from cycle 1, datoA=32'hAAAA0000 -> cycle 2: grant=0001, selDato=00; cycle 3: datoOutput=32'hAAAA0000, datoValid=1.
3. req=1111; each owner drops its req bit after 2 grant cycles, then reasserts it -> grant sequence 0001, 0010, 0100, 1000, 0001 with no grant=0000 cycle between owners.
4. Owner=2 drops with req=1001 pending -> next grant=1000 (wrap order 3 before 0), then 0001 when owner 3 releases.
5. ARB_TIMEOUT_EN, MAX_HOLD=4, req=0011 held -> grant alternates 0001 x4 cycles, 0010 x4 cycles. Same stimulus without the macro -> grant=0001 forever.
6. reset pulsed while grant=0100 -> next edge grant=0000, selDato=00, datoValid=0. Then req=0110 -> grant=0010 (search restarts at 0).
